// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer controller.
// Holds the FSM state enumeration, LFSR seed and tap mask, the BCD saturation
// value, and the helper functions for the LFSR step and the 4-digit BCD increment.
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RAND = 3'd1,
    ST_TIMING    = 3'd2,
    ST_DONE      = 3'd3,
    ST_EARLY     = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to bits 15,13,12,10 of the shift register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] BCD_MAX   = 16'h9999;

  // One Fibonacci step: shift left and feed the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Add one to a 4-digit packed BCD value; a digit at 9 wraps to 0 and carries.
  function automatic logic [15:0] bcd_inc(input logic [15:0] cur);
    logic [15:0] res;
    logic        carry;
    res   = cur;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cur[i*4 +: 4] == 4'd9) begin
          res[i*4 +: 4] = 4'd0;
          carry         = 1'b1;
        end else begin
          res[i*4 +: 4] = cur[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end else begin
        res[i*4 +: 4] = cur[i*4 +: 4];
        carry         = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_bcd_counter4.sv
// Four-digit BCD result counter for the reaction timer.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, clears the count
//   clear - synchronous clear to 0 (takes priority over inc)
//   inc   - add one ms to the count; ignored once the count is at 9999
//   value - current packed BCD count, [15:12] = thousands
//   sat   - high while the count sits at 9999
module bcd_counter4
  import reaction_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] value,
  output logic        sat
);

  logic [15:0] value_r;

  // Count register: reset/clear to zero, otherwise BCD increment up to the ceiling.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= 16'h0000;
    end else if (clear) begin
      value_r <= 16'h0000;
    end else if (inc && (value_r != BCD_MAX)) begin
      value_r <= bcd_inc(value_r);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;
  assign sat   = (value_r == BCD_MAX);

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer controller: after a start press, waits a pseudo-random delay,
// lights led_go, and measures in ms how long the subject takes to press stop.
// Ports:
//   clk        - system clock, all state updates on its rising edge
//   rst        - synchronous active-high reset
//   start_key  - debounced start button, active low
//   stop_key   - debounced stop/react button, active low
//   led_go     - high in TIMING (subject must react)
//   early      - high in EARLY (stop pressed before GO)
//   done       - high in DONE (result_bcd holds a valid time)
//   result_bcd - reaction time in ms, 4 packed BCD digits
module reaction_timer_ctrl
  import reaction_timer_pkg::*;
#(
  parameter int MS_TICK      = 50000,
  parameter int MIN_DELAY_MS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_key,
  input  logic        stop_key,
  output logic        led_go,
  output logic        early,
  output logic        done,
  output logic [15:0] result_bcd
);

  localparam int PRESC_W = (MS_TICK > 1) ? $clog2(MS_TICK) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(MS_TICK - 1);

  state_e               state_r;
  state_e               state_nxt_s;
  logic                 start_prev_r;
  logic                 stop_prev_r;
  logic [15:0]          lfsr_r;
  logic [15:0]          delay_ms_r;
  logic [PRESC_W-1:0]   presc_r;
  logic                 led_go_r;
  logic                 early_r;
  logic                 done_r;

  logic                 start_press_s;
  logic                 stop_press_s;
  logic                 ms_tick_s;
  logic                 load_delay_s;
  logic                 cnt_clear_s;
  logic                 cnt_inc_s;
  logic                 cnt_sat_s;
  logic                 nxt_counting_s;
  logic [15:0]          cnt_value_s;

  // Press detection and the ms tick strobe.
  always_comb begin
    // A key held low yields one press because its history follows it down.
    start_press_s  = start_prev_r & ~start_key;
    stop_press_s   = stop_prev_r & ~stop_key;
    ms_tick_s      = ((state_r == ST_WAIT_RAND) || (state_r == ST_TIMING)) &&
                     (presc_r == PRESC_LAST);
    nxt_counting_s = (state_nxt_s == ST_WAIT_RAND) || (state_nxt_s == ST_TIMING);
  end

  // Next-state decision and per-edge control strobes.
  always_comb begin
    state_nxt_s  = state_r;
    load_delay_s = 1'b0;
    cnt_clear_s  = 1'b0;
    cnt_inc_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_EARLY: begin
        if (start_press_s) begin
          state_nxt_s  = ST_WAIT_RAND;
          load_delay_s = 1'b1;
          cnt_clear_s  = 1'b1;
        end else begin
          state_nxt_s  = state_r;
        end
      end
      ST_WAIT_RAND: begin
        // Stop beats the final tick: a press on that edge is still early.
        if (stop_press_s) begin
          state_nxt_s = ST_EARLY;
          cnt_clear_s = 1'b1;
        end else if (ms_tick_s && (delay_ms_r <= 16'd1)) begin
          state_nxt_s = ST_TIMING;
        end else begin
          state_nxt_s = ST_WAIT_RAND;
        end
      end
      ST_TIMING: begin
        // Stop freezes the result, so a coincident tick is not counted.
        if (stop_press_s) begin
          state_nxt_s = ST_DONE;
        end else if (cnt_sat_s) begin
          state_nxt_s = ST_DONE;
        end else if (ms_tick_s) begin
          state_nxt_s = ST_TIMING;
          cnt_inc_s   = 1'b1;
        end else begin
          state_nxt_s = ST_TIMING;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM, delay, prescaler, LFSR, key history and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      start_prev_r <= 1'b1;
      stop_prev_r  <= 1'b1;
      lfsr_r       <= LFSR_SEED;
      delay_ms_r   <= 16'd0;
      presc_r      <= '0;
      led_go_r     <= 1'b0;
      early_r      <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      start_prev_r <= start_key;
      stop_prev_r  <= stop_key;
      lfsr_r       <= lfsr_next(lfsr_r);

      if (load_delay_s) begin
        delay_ms_r <= 16'(MIN_DELAY_MS) + {5'd0, lfsr_r[10:0]};
      end else if ((state_r == ST_WAIT_RAND) && ms_tick_s && (delay_ms_r != 16'd0)) begin
        delay_ms_r <= delay_ms_r - 16'd1;
      end else begin
        delay_ms_r <= delay_ms_r;
      end

      // The prescaler restarts on every entry and on each tick, and rests at 0
      // outside the counting states.
      if (load_delay_s || ms_tick_s || !nxt_counting_s) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PRESC_W'(1);
      end

      led_go_r <= (state_nxt_s == ST_TIMING);
      early_r  <= (state_nxt_s == ST_EARLY);
      done_r   <= (state_nxt_s == ST_DONE);
    end
  end

  bcd_counter4 u_result (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear_s),
    .inc   (cnt_inc_s),
    .value (cnt_value_s),
    .sat   (cnt_sat_s)
  );

  assign led_go     = led_go_r;
  assign early      = early_r;
  assign done       = done_r;
  assign result_bcd = cnt_value_s;

endmodule

// File: doc/reaction_timer_ctrl.md
REACTION_TIMER_CTRL -- requirements
Module: reaction_timer_ctrl

Interface
REQ-001 Parameter MS_TICK, default 50000, clock cycles per 1 ms tick (50 MHz clk).
REQ-002 Parameter MIN_DELAY_MS, default 1000, minimum random wait before GO.
REQ-003 Port clk  input  1  system clock; every register updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port start_key  input  1  debounced start button; idle high, pressed low.
REQ-006 Port stop_key  input  1  debounced stop/react button; idle high, pressed low.
REQ-007 Port led_go  output  1  high while the subject must react (TIMING state).
REQ-008 Port early  output  1  high in EARLY state (stop pressed before GO).
REQ-009 Port done  output  1  high in DONE state (valid result held).
REQ-010 Port result_bcd  output  16  reaction time in ms, 4 BCD digits, [15:12] thousands.

Function
REQ-011 A press SHALL be a 1->0 transition, detected against a per-key previous-value register that resets to 1; a press is acted on at the clock edge ending the first cycle the key reads 0, so a key held low gives exactly one press.
REQ-012 States SHALL be IDLE, WAIT_RAND, TIMING, DONE, EARLY.
REQ-013 IDLE: start press -> WAIT_RAND; stop press ignored.
REQ-014 On entry to WAIT_RAND, delay_ms SHALL load MIN_DELAY_MS + lfsr[10:0] (range MIN_DELAY_MS..MIN_DELAY_MS+2047); result_bcd clears to 0; prescaler clears to 0.
REQ-015 The LFSR SHALL be 16-bit maximal-length Fibonacci (taps 16,14,13,11), free-running every cycle, reset seed 16'hACE1, never all-zero.
REQ-016 The prescaler SHALL count 0..MS_TICK-1 in WAIT_RAND and TIMING only, wrapping to 0 and asserting a 1-cycle ms_tick at MS_TICK-1; held 0 in other states.
REQ-017 WAIT_RAND: each ms_tick decrements delay_ms; the tick that brings it to 0 -> TIMING, prescaler restarting at 0.
REQ-018 WAIT_RAND: a stop press -> EARLY at once, result_bcd = 0; a stop press on the same edge as the final tick SHALL take priority (EARLY).
REQ-019 TIMING: each ms_tick SHALL BCD-increment result_bcd (digit 9 wraps to 0 with carry); at 16'h9999 it saturates and the state -> DONE.
REQ-020 TIMING: stop press -> DONE on that edge, result_bcd frozen; a tick on the same edge SHALL NOT increment.
REQ-021 DONE/EARLY: result_bcd held; start press -> WAIT_RAND (new delay per REQ-014); stop press ignored.
REQ-022 start_key presses SHALL be ignored in WAIT_RAND and TIMING.
REQ-023 Outputs SHALL be Moore, decoded from registered state: led_go=TIMING, early=EARLY, done=DONE.

Reset
REQ-024 rst high at a clock edge SHALL force state IDLE, result_bcd 0, prescaler 0, delay_ms 0, key history 1, LFSR seed; led_go, early, done low the following cycle.
REQ-025 rst mid-run (any state) SHALL abort with no residual tick, press or result.
REQ-026 rst SHALL override every simultaneous press or tick.

Structure
REQ-027 Package reaction_timer_pkg SHALL hold the state enumeration, LFSR seed, tap constant and BCD saturation value 16'h9999.
REQ-028 Sub-module bcd_counter4 (clear, inc, 16-bit BCD value, saturate flag) SHALL implement the result counter; all else inline.
REQ-029 All state SHALL be one clock domain; no latches, no asynchronous resets.

Verification (MS_TICK=4, MIN_DELAY_MS=2)
REQ-030 Reset, start low one cycle -> WAIT_RAND; after (2+lfsr[10:0])*4 cycles led_go=1.
REQ-031 GO, then stop low after 5 ticks -> done=1, result_bcd=16'h0005, led_go=0, value stable 100 cycles.
REQ-032 Stop low during WAIT_RAND -> early=1, result_bcd=0, led_go never high; start press -> WAIT_RAND.
REQ-033 No stop for 9999 ticks -> result_bcd=16'h9999, done=1; check 16'h0009->16'h0010 and 16'h0099->16'h0100 carries.
REQ-034 Stop held low across GO -> no press detected, timing continues; start held low -> exactly one restart.
REQ-035 rst pulse in TIMING at result 16'h0003 -> next cycle IDLE, outputs 0, result_bcd=0.
